// File: rtl/gf128_pkg.sv
// ============================================================================
// Module : gf128_pkg
// Desc   : GF(2^128) GCM-convention types, reduction constant and helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gf128_pkg;

    typedef logic [127:0] gf128_t;

    localparam gf128_t GF128_R = 128'hE1 << 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf128_state_t;

    // Multiply V by x in the reflected GCM bit order, reducing by the field polynomial.
    function automatic gf128_t gf128_mulx(input gf128_t v);
        return (v >> 1) ^ (v[0] ? GF128_R : 128'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gf128_digit_step.sv
// ============================================================================
// Module : gf128_digit_step
// Desc   : Combinational chain of DIGIT_W multiply-accumulate bit stages.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gf128_digit_step
    import gf128_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  gf128_t             i_z,
    input  gf128_t             i_v,
    input  logic [DIGIT_W-1:0] i_x,
    output gf128_t             o_z,
    output gf128_t             o_v
);

    gf128_t w_z [0:DIGIT_W];
    gf128_t w_v [0:DIGIT_W];

    assign w_z[0] = i_z;
    assign w_v[0] = i_v;

    // Stage g consumes digit bit DIGIT_W-1-g, so the MSB of the digit goes first.
    for (genvar g = 0; g < DIGIT_W; g++) begin : g_stage
        assign w_z[g+1] = i_x[DIGIT_W-1-g] ? (w_z[g] ^ w_v[g]) : w_z[g];
        assign w_v[g+1] = gf128_mulx(w_v[g]);
    end

    assign o_z = w_z[DIGIT_W];
    assign o_v = w_v[DIGIT_W];

endmodule

`default_nettype wire

// File: rtl/gf128_mul_ds.sv
// ============================================================================
// Module : gf128_mul_ds
// Desc   : Digit-serial GF(2^128) GCM multiplier with ready/valid handshakes.
//          Define GF128_MUL_ACC_EN to add the acc_i GHASH accumulate port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gf128_mul_ds
    import gf128_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int DIGIT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
`ifdef GF128_MUL_ACC_EN
    input  logic             acc_i,
`endif
    output logic [WIDTH-1:0] result_o
);

    localparam int N     = 128 / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    if (WIDTH != 128) begin : g_bad_width
        $error("gf128_mul_ds: WIDTH must be 128");
    end

    if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 || DIGIT_W == 8 ||
          DIGIT_W == 16 || DIGIT_W == 32 || DIGIT_W == 64 || DIGIT_W == 128)) begin : g_bad_digit
        $error("gf128_mul_ds: DIGIT_W must be a power of two from 1 to 128");
    end

    gf128_state_t     r_state;
    gf128_t           r_x;
    gf128_t           r_v;
    gf128_t           r_z;
    logic [CNT_W-1:0] r_cnt;
    gf128_t           r_result;

    gf128_t w_z_nxt;
    gf128_t w_v_nxt;
    gf128_t w_x_load;
    logic   w_accept;

    assign in_ready_o  = (r_state == IDLE) || ((r_state == DONE) && out_ready_i);
    assign out_valid_o = (r_state == DONE);
    assign result_o    = r_result;
    assign w_accept    = in_valid_i && in_ready_o;

`ifdef GF128_MUL_ACC_EN
    gf128_t r_prev;
    gf128_t w_prev;

    // An accept in DONE coincides with the handshake that is about to update r_prev.
    assign w_prev   = (r_state == DONE) ? r_result : r_prev;
    assign w_x_load = a_i ^ (acc_i ? w_prev : 128'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else if ((r_state == DONE) && out_ready_i) begin
            r_prev <= r_result;
        end
    end
`else
    assign w_x_load = a_i;
`endif

    gf128_digit_step #(
        .DIGIT_W (DIGIT_W)
    ) u_step (
        .i_z (r_z),
        .i_v (r_v),
        .i_x (r_x[127 -: DIGIT_W]),
        .o_z (w_z_nxt),
        .o_v (w_v_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_v      <= '0;
            r_z      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x     <= w_x_load;
                        r_v     <= b_i;
                        r_z     <= '0;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_z   <= w_z_nxt;
                    r_v   <= w_v_nxt;
                    r_x   <= r_x << DIGIT_W;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_result <= w_z_nxt;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        if (in_valid_i) begin
                            r_x     <= w_x_load;
                            r_v     <= b_i;
                            r_z     <= '0;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gf128_mul_ds.sv
// ============================================================================
// Module : tb_gf128_mul_ds
// Desc   : Self-checking bench for gf128_mul_ds against a polynomial-arithmetic
//          reference model. Define GF128_MUL_ACC_EN to also exercise acc_i.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gf128_mul_ds;

    localparam int DIGIT_W = 8;
    localparam int N       = 128 / DIGIT_W;

    localparam logic [127:0] C_TC2_C = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] C_TC2_H = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C_TC2_R = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] C_ONE   = 128'h80000000000000000000000000000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] a_i;
    logic [127:0] b_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic         acc_i;
    logic [127:0] result_o;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    gf128_mul_ds #(
        .WIDTH   (128),
        .DIGIT_W (DIGIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
`ifdef GF128_MUL_ACC_EN
        .acc_i       (acc_i),
`endif
        .result_o    (result_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rev128(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = x[127-i];
        return r;
    endfunction

    // Ordinary polynomial product in x^i order, then long-division reduction.
    function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] p;
        logic [255:0] poly;
        logic [127:0] ar;
        logic [127:0] br;
        ar   = rev128(a);
        br   = rev128(b);
        p    = '0;
        poly = (256'h1 << 128) | 256'h87;
        for (int i = 0; i < 128; i++)
            if (ar[i]) p = p ^ ({128'd0, br} << i);
        for (int i = 254; i >= 128; i--)
            if (p[i]) p = p ^ (poly << (i - 128));
        return rev128(p[127:0]);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid_o && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                          input logic acc, input logic [127:0] exp);
        int w;
        int cyc;
        w = 0;
        while (!in_ready_o && w < 400) begin
            tick();
            w++;
        end
        a_i        = a;
        b_i        = b;
        acc_i      = acc;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        acc_i      = 1'b0;
        wait_out(cyc);
        check({tag, " latency"}, 128'(cyc), 128'(N));
        check({tag, " result"}, result_o, exp);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({tag, " released"}, 128'(out_valid_o), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ta;
        logic [127:0] tb;
        logic [127:0] held;
        logic [127:0] expq[$];
        int           cyc;
        int           sent;
        int           got;
        int           last;
        logic         hin;
        logic         hout;
        logic         seen;

        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        acc_i       = 1'b0;
        a_i         = '0;
        b_i         = '0;
        repeat (3) tick();
        check("reset in_ready", 128'(in_ready_o), 128'd1);
        check("reset out_valid", 128'(out_valid_o), 128'd0);
        check("reset result", result_o, 128'd0);
        rst = 1'b0;
        tick();

        run_op("tc2", C_TC2_C, C_TC2_H, 1'b0, C_TC2_R);
        run_op("identity", C_ONE, C_TC2_H, 1'b0, C_TC2_H);
        check("result held in idle", result_o, C_TC2_H);
        run_op("zero", 128'd0, C_TC2_H, 1'b0, 128'd0);
        for (int k = 0; k < 4; k++) begin
            ta = rand128();
            tb = rand128();
            run_op("random", ta, tb, 1'b0, ref_mul(ta, tb));
        end

        // Back-pressure, then same-cycle release and re-accept.
        ta = rand128();
        tb = rand128();
        a_i        = ta;
        b_i        = tb;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        wait_out(cyc);
        held = result_o;
        check("bp result", held, ref_mul(ta, tb));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp stable", result_o, held);
            check("bp in_ready", 128'(in_ready_o), 128'd0);
            check("bp out_valid", 128'(out_valid_o), 128'd1);
        end
        ta          = rand128();
        tb          = rand128();
        a_i         = ta;
        b_i         = tb;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        #1;
        check("bp ready follows out_ready", 128'(in_ready_o), 128'd1);
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("bp reaccept busy", 128'(in_ready_o), 128'd0);
        check("bp reaccept valid low", 128'(out_valid_o), 128'd0);
        wait_out(cyc);
        check("bp second latency", 128'(cyc), 128'(N));
        check("bp second result", result_o, ref_mul(ta, tb));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Full streaming of 10 random pairs.
        sent        = 0;
        got         = 0;
        cyc         = 0;
        last        = -1;
        a_i         = rand128();
        b_i         = rand128();
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        while (got < 10 && cyc < 2000) begin
            hin  = in_valid_i && in_ready_o;
            hout = out_valid_o && out_ready_i;
            if (hout) begin
                if (expq.size() == 0) begin
                    check("stream unexpected output", 128'd1, 128'd0);
                end else begin
                    check("stream result", result_o, expq.pop_front());
                end
                if (last >= 0) check("stream period", 128'(cyc - last), 128'(N + 1));
                last = cyc;
                got++;
            end
            if (hin) expq.push_back(ref_mul(a_i, b_i));
            tick();
            cyc++;
            if (hin) begin
                sent++;
                if (sent < 10) begin
                    a_i = rand128();
                    b_i = rand128();
                end else begin
                    in_valid_i = 1'b0;
                end
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("stream count", 128'(got), 128'd10);

        // Reset during BUSY.
        a_i        = rand128();
        b_i        = rand128();
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst out_valid", 128'(out_valid_o), 128'd0);
        check("midrst in_ready", 128'(in_ready_o), 128'd1);
        check("midrst result", result_o, 128'd0);
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < N + 10; k++) begin
            tick();
            if (out_valid_o) seen = 1'b1;
        end
        check("midrst no stale output", 128'(seen), 128'd0);

`ifdef GF128_MUL_ACC_EN
        run_op("acc block1", C_TC2_C, C_TC2_H, 1'b0, C_TC2_R);
        run_op("acc block2", 128'h00000000000000000000000000000080, C_TC2_H, 1'b1,
               128'hf38cbb1ad69223dcc3457ae5b6b0f885);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
